// File: rtl/text_mem_wr_arbiter.sv
// text_mem_wr_arbiter
//   Owns the write port of the character RAM. Two requesters (A: UART
//   character writer, B: second host) and a screen-clear sequencer share it.
//   Every RAM write uses a fixed 4-cycle slot: IDLE -> SETUP -> WR1 -> WR2.
//   Address and data settle in SETUP. mem_wren is high in WR1/WR2 only, so the
//   RAM sees stable address and data for the whole enable pulse.
//
// Ports
//   clock100, reset              clock and synchronous active-high reset
//   a_req/a_addr/a_data/a_ack    port A request (level) and 1-cycle accept pulse
//   b_req/b_addr/b_data/b_ack    port B request (level) and 1-cycle accept pulse
//   clear_start, clear_busy      start pulse and pending/running flag for the clear
//   drop                         1-cycle pulse: the accepted request was out of range
//   mem_wraddress/mem_data/mem_wren  RAM write port
module text_mem_wr_arbiter #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 3200,
    parameter logic [DATA_W-1:0] FILL_CHAR = 8'h20
) (
    input  logic              clock100,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ack,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ack,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              drop,
    output logic [ADDR_W-1:0] mem_wraddress,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren
);

    typedef enum logic [1:0] {IDLE, SETUP, WR1, WR2} state_t;

    // The extra top bit keeps the range compare exact even if DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_X    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(DEPTH - 1);

    state_t            state_reg;
    logic [ADDR_W-1:0] clear_cnt_reg;
    logic              clear_busy_reg;
    logic              last_grant_reg;   // 1 = B was granted last
    logic              slot_clear_reg;   // current slot belongs to the clear sequencer
    logic              slot_oor_reg;     // current slot is an out-of-range drop
    logic              a_ack_reg;
    logic              b_ack_reg;
    logic              drop_reg;
    logic              mem_wren_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_data_reg;

    logic              grant_a_next;
    logic              grant_b_next;
    logic [ADDR_W-1:0] win_addr_next;
    logic [DATA_W-1:0] win_data_next;
    logic              win_oor_next;

    // Round-robin between A and B; the clear sequencer masks both while busy.
    always_comb begin
        grant_a_next = 1'b0;
        grant_b_next = 1'b0;
        if (!clear_busy_reg) begin
            if (a_req && b_req) begin
                grant_a_next = last_grant_reg;
                grant_b_next = !last_grant_reg;
            end else begin
                grant_a_next = a_req;
                grant_b_next = b_req;
            end
        end
        win_addr_next = grant_b_next ? b_addr : a_addr;
        win_data_next = grant_b_next ? b_data : a_data;
        win_oor_next  = ({1'b0, win_addr_next} >= DEPTH_X);
    end

    always_ff @(posedge clock100) begin
        if (reset) begin
            state_reg      <= IDLE;
            clear_cnt_reg  <= '0;
            clear_busy_reg <= 1'b0;
            last_grant_reg <= 1'b1;
            slot_clear_reg <= 1'b0;
            slot_oor_reg   <= 1'b0;
            a_ack_reg      <= 1'b0;
            b_ack_reg      <= 1'b0;
            drop_reg       <= 1'b0;
            mem_wren_reg   <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            a_ack_reg <= 1'b0;
            b_ack_reg <= 1'b0;
            drop_reg  <= 1'b0;

            // A start while busy is ignored; a start mid-slot waits for IDLE.
            if (clear_start && !clear_busy_reg) begin
                clear_busy_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (clear_busy_reg) begin
                        mem_addr_reg   <= clear_cnt_reg;
                        mem_data_reg   <= FILL_CHAR;
                        slot_clear_reg <= 1'b1;
                        slot_oor_reg   <= 1'b0;
                        state_reg      <= SETUP;
                    end else if (grant_a_next || grant_b_next) begin
                        mem_addr_reg   <= win_addr_next;
                        mem_data_reg   <= win_data_next;
                        slot_clear_reg <= 1'b0;
                        slot_oor_reg   <= win_oor_next;
                        a_ack_reg      <= grant_a_next;
                        b_ack_reg      <= grant_b_next;
                        drop_reg       <= win_oor_next;
                        last_grant_reg <= grant_b_next;
                        state_reg      <= SETUP;
                    end
                end
                SETUP: begin
                    mem_wren_reg <= !slot_oor_reg;
                    state_reg    <= WR1;
                end
                WR1: begin
                    state_reg <= WR2;
                end
                WR2: begin
                    mem_wren_reg <= 1'b0;
                    state_reg    <= IDLE;
                    if (slot_clear_reg) begin
                        if (clear_cnt_reg == LAST_CELL) begin
                            clear_cnt_reg  <= '0;
                            clear_busy_reg <= 1'b0;
                        end else begin
                            clear_cnt_reg <= clear_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign a_ack         = a_ack_reg;
    assign b_ack         = b_ack_reg;
    assign drop          = drop_reg;
    assign clear_busy    = clear_busy_reg;
    assign mem_wren      = mem_wren_reg;
    assign mem_wraddress = mem_addr_reg;
    assign mem_data      = mem_data_reg;

endmodule

// File: tb/tb_text_mem_wr_arbiter.sv
// Testbench for text_mem_wr_arbiter (DEPTH reduced to 16 so clears are short).
// A slot-level reference model predicts accepts and RAM writes into queues;
// a monitor pops and compares whenever the DUT acks or writes.
module tb_text_mem_wr_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam logic [7:0] FILL = 8'h20;

    logic              clock100 = 1'b0;
    logic              reset;
    logic              a_req, b_req, clear_start;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              a_ack, b_ack, clear_busy, drop, mem_wren;
    logic [ADDR_W-1:0] mem_wraddress;
    logic [DATA_W-1:0] mem_data;

    text_mem_wr_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FILL_CHAR(FILL)
    ) dut (
        .clock100(clock100), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_ack(a_ack),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_ack(b_ack),
        .clear_start(clear_start), .clear_busy(clear_busy), .drop(drop),
        .mem_wraddress(mem_wraddress), .mem_data(mem_data), .mem_wren(mem_wren)
    );

    always #5 clock100 = ~clock100;

    typedef struct { bit port; bit drp; int cyc; } ack_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; int cyc; } wr_t;

    ack_t ack_q[$];
    wr_t  wr_q[$];
    bit   grant_log[$];
    int   grant_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 0;
    bit aborted = 1;
    bit m_clear = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: one slot occupies four cycles; the clear walks cells
    // 0..DEPTH-1 with FILL; otherwise A/B alternate on a tie, else the single
    // requester wins. Decisions are taken from the inputs seen in an idle cycle.
    initial begin
        int  slot_left = 0;
        bit  slot_is_clear = 0;
        int  cnt = 0;
        bit  last = 1;
        bit  start, pick, oor;
        logic [ADDR_W-1:0] ad;
        logic [DATA_W-1:0] dt;
        forever begin
            @(posedge clock100);
            cyc = cyc + 1;
            if (reset) begin
                slot_left = 0; slot_is_clear = 0; cnt = 0; last = 1; m_clear = 0;
                ack_q.delete(); wr_q.delete(); aborted = 1;
            end else begin
                start = clear_start && !m_clear;
                if (slot_left == 0) begin
                    if (m_clear) begin
                        wr_q.push_back('{ADDR_W'(cnt), FILL, cyc + 1});
                        slot_left = 3; slot_is_clear = 1;
                    end else if (a_req || b_req) begin
                        pick = (a_req && b_req) ? !last : b_req;
                        last = pick;
                        ad = pick ? b_addr : a_addr;
                        dt = pick ? b_data : a_data;
                        oor = (int'(ad) >= DEPTH);
                        ack_q.push_back('{pick, oor, cyc});
                        if (!oor) wr_q.push_back('{ad, dt, cyc + 1});
                        slot_left = 3; slot_is_clear = 0;
                    end
                end else begin
                    slot_left = slot_left - 1;
                    if (slot_left == 0 && slot_is_clear) begin
                        if (cnt == DEPTH - 1) begin cnt = 0; m_clear = 0; end
                        else cnt = cnt + 1;
                    end
                end
                if (start) m_clear = 1;
            end
        end
    end

    // Monitor: compares whatever the DUT presents against the model queues.
    initial begin
        bit prev_wren = 0;
        int run = 0;
        logic [ADDR_W-1:0] run_addr;
        logic [DATA_W-1:0] run_data;
        ack_t ea;
        wr_t  ew;
        forever begin
            @(negedge clock100);
            if (mon_en) begin
                chk("clear_busy", clear_busy, m_clear);
                if (a_ack === 1'b1 || b_ack === 1'b1) begin
                    grant_log.push_back(b_ack);
                    grant_cyc.push_back(cyc);
                    if (ack_q.size() == 0) begin
                        chk("ack_unexpected", {a_ack, b_ack}, 2'b00);
                    end else begin
                        ea = ack_q.pop_front();
                        chk("ack_port", {a_ack, b_ack}, ea.port ? 2'b01 : 2'b10);
                        chk("ack_drop", drop, ea.drp);
                        chk("ack_cycle", cyc, ea.cyc);
                    end
                end else if (drop !== 1'b0) begin
                    chk("drop_without_ack", drop, 1'b0);
                end
                if (mem_wren === 1'b1 && !prev_wren) begin
                    aborted = 0;
                    run = 1; run_addr = mem_wraddress; run_data = mem_data;
                    if (wr_q.size() == 0) begin
                        chk("wren_unexpected", mem_wren, 1'b0);
                    end else begin
                        ew = wr_q.pop_front();
                        chk("wr_addr", mem_wraddress, ew.addr);
                        chk("wr_data", mem_data, ew.data);
                        chk("wr_cycle", cyc, ew.cyc);
                    end
                end else if (mem_wren === 1'b1) begin
                    run++;
                    chk("wr_hold", {mem_wraddress, mem_data}, {run_addr, run_data});
                    chk("wren_len_max", (run > 2), 1'b0);
                end else if (prev_wren) begin
                    chk("wren_len", (run == 2) || aborted, 1'b1);
                end
                prev_wren = (mem_wren === 1'b1);
            end
        end
    end

    // Drive one request and hold it until accepted (bounded wait).
    task automatic issue(input bit port, input logic [ADDR_W-1:0] ad, input logic [DATA_W-1:0] dt);
        int n = 0;
        @(negedge clock100);
        if (port) begin b_req = 1; b_addr = ad; b_data = dt; end
        else      begin a_req = 1; a_addr = ad; a_data = dt; end
        do begin
            @(negedge clock100);
            n++;
        end while (!(port ? b_ack : a_ack) && n < 400);
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL ack_timeout port=%0d actual=none required=ack", port);
        end
        if (port) b_req = 0; else a_req = 0;
    endtask

    task automatic do_reset();
        @(negedge clock100);
        reset = 1;
        repeat (3) @(negedge clock100);
        reset = 0;
    endtask

    initial begin
        int n;
        reset = 1; a_req = 0; b_req = 0; clear_start = 0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0;
        repeat (3) @(negedge clock100);
        chk("rst_ack", {a_ack, b_ack, drop}, 3'b000);
        chk("rst_wren", mem_wren, 1'b0);
        chk("rst_busy", clear_busy, 1'b0);
        chk("rst_addr_data", {mem_wraddress, mem_data}, '0);
        reset = 0;
        mon_en = 1;

        // single A write
        issue(0, 12'd5, 8'h41);
        repeat (4) @(negedge clock100);

        // tie between A and B right after reset: A first, then alternation
        do_reset();
        grant_log.delete(); grant_cyc.delete();
        fork
            begin issue(0, 12'd1, 8'h11); issue(0, 12'd2, 8'h12); end
            begin issue(1, 12'd3, 8'h13); issue(1, 12'd4, 8'h14); end
        join
        chk("rr_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("rr_order", {grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 4'b0101);
            for (int i = 1; i < 4; i++) chk("rr_spacing", grant_cyc[i] - grant_cyc[i-1], 4);
        end
        repeat (4) @(negedge clock100);

        // full clear; a second start mid-clear must not restart it
        clear_start = 1;
        @(negedge clock100);
        clear_start = 0;
        n = 0;
        while (clear_busy && n < 1000) begin
            n++;
            clear_start = (n == 10);
            @(negedge clock100);
        end
        clear_start = 0;
        chk("clear_busy_len", n, 64);

        // B request raised 3 cycles into a clear is stalled until it ends
        clear_start = 1;
        @(negedge clock100);
        clear_start = 0;
        @(negedge clock100);
        issue(1, 12'd9, 8'h42);
        chk("b_ack_after_clear", clear_busy, 1'b0);
        repeat (4) @(negedge clock100);

        // range boundary: DEPTH is dropped, DEPTH-1 written
        issue(0, 12'd16, 8'h43);
        issue(1, 12'd15, 8'h44);
        issue(0, 12'hFFF, 8'h45);
        repeat (4) @(negedge clock100);

        // reset in WR1 aborts the write, then a fresh request works
        issue(0, 12'd6, 8'h46);
        @(negedge clock100);
        chk("wr1_wren", mem_wren, 1'b1);
        reset = 1;
        @(negedge clock100);
        chk("abort_wren", mem_wren, 1'b0);
        reset = 0;
        issue(0, 12'd7, 8'h55);
        repeat (4) @(negedge clock100);

        // randomized traffic on both ports with occasional clears
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock100);
                    issue(0, ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clock100);
                    issue(1, ADDR_W'($urandom_range(0, 31)), DATA_W'($urandom));
                end
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    repeat ($urandom_range(60, 150)) @(negedge clock100);
                    clear_start = 1;
                    @(negedge clock100);
                    clear_start = 0;
                end
            end
        join
        repeat (100) @(negedge clock100);
        chk("ack_q_drained", ack_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
